// File: rtl/axi_mem_responder.sv
// AXI4 memory responder backed by a byte-enabled on-chip RAM; IDs are echoed, bursts are INCR.
// Read and write FSMs run independently, with one burst of each kind in flight.
//
// state   | meaning
// R_IDLE  | waiting for AR
// R_FETCH | RAM read in flight (registered RAM output)
// R_SEND  | beat presented on R, held until rready
// W_IDLE  | waiting for AW
// W_DATA  | accepting W beats until wlast
// W_RESP  | B response presented, held until bready
module axi_mem_responder #(
  parameter int ADDR_WIDTH     = 48,
  parameter int DATA_WIDTH     = 512,
  parameter int ID_WIDTH       = 9,
  parameter int MEM_WORDS_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [ID_WIDTH-1:0]     s_arid,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic [ID_WIDTH-1:0]     s_rid,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [1:0]              s_bresp,
  output logic [ID_WIDTH-1:0]     s_bid
);
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int BYTE_LOG2  = $clog2(DATA_BYTES);
  localparam int WIN        = MEM_WORDS_LOG2 + BYTE_LOG2;
  localparam logic [MEM_WORDS_LOG2-1:0] IDX_ONE = MEM_WORDS_LOG2'(1);

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [DATA_WIDTH-1:0]     mem [2**MEM_WORDS_LOG2];
  logic [DATA_WIDTH-1:0]     ram_q;
  logic                      ram_re, ram_we;
  logic [MEM_WORDS_LOG2-1:0] ram_raddr;

  logic                      rdy_en;
  logic [ID_WIDTH-1:0]       r_id, w_id;
  logic [7:0]                r_left, w_left;
  logic [MEM_WORDS_LOG2-1:0] r_idx, w_idx;
  logic                      r_err, w_err, w_mis, w_over;

  logic                      ar_hs, r_hs, aw_hs, w_hs;
  logic                      ar_err, aw_err;
  logic [MEM_WORDS_LOG2-1:0] ar_idx, aw_idx;

  assign ar_hs  = s_arvalid && s_arready;
  assign r_hs   = s_rvalid && s_rready;
  assign aw_hs  = s_awvalid && s_awready;
  assign w_hs   = s_wvalid && s_wready;
  assign ar_idx = s_araddr[WIN-1:BYTE_LOG2];
  assign aw_idx = s_awaddr[WIN-1:BYTE_LOG2];
  assign ar_err = (s_arsize != 3'(BYTE_LOG2)) || (|s_araddr[ADDR_WIDTH-1:WIN]);
  assign aw_err = (s_awsize != 3'(BYTE_LOG2)) || (|s_awaddr[ADDR_WIDTH-1:WIN]);

  // Non-blocking read and write of the same word in one edge gives read-first data.
  always_ff @(posedge clk) begin
    if (ram_re) ram_q <= mem[ram_raddr];
    for (int b = 0; b < DATA_BYTES; b++)
      if (ram_we && s_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_wdata[b*8 +: 8];
  end

  // Keeps both address readies low while reset is asserted even though IDLE is the reset state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  always_comb begin
    r_next    = r_state;
    ram_re    = 1'b0;
    ram_raddr = r_idx + IDX_ONE;
    case (r_state)
      R_IDLE:
        if (ar_hs) begin
          r_next    = R_FETCH;
          ram_re    = 1'b1;
          ram_raddr = ar_idx;
        end
      R_FETCH: r_next = R_SEND;
      R_SEND:
        if (s_rready) begin
          if (r_left == 8'd0) begin
            r_next = R_IDLE;
          end else begin
            r_next = R_FETCH;
            ram_re = 1'b1;
          end
        end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_left  <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_id   <= s_arid;
        r_left <= s_arlen;
        r_idx  <= ar_idx;
        r_err  <= ar_err;
      end else if (r_hs) begin
        r_left <= r_left - 8'd1;
        r_idx  <= r_idx + IDX_ONE;
      end
    end
  end

  assign s_arready = rdy_en && (r_state == R_IDLE);
  assign s_rvalid  = (r_state == R_SEND);
  assign s_rdata   = (s_rvalid && !r_err) ? ram_q : '0;
  assign s_rresp   = (s_rvalid && r_err) ? 2'b10 : 2'b00;
  assign s_rlast   = s_rvalid && (r_left == 8'd0);
  assign s_rid     = r_id;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && s_wlast) w_next = W_RESP;
      W_RESP:  if (s_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Beats after the one numbered awlen are accepted but never reach the RAM.
  assign ram_we = w_hs && !w_err && !w_over;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_left  <= '0;
      w_idx   <= '0;
      w_err   <= 1'b0;
      w_mis   <= 1'b0;
      w_over  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        w_id   <= s_awid;
        w_left <= s_awlen;
        w_idx  <= aw_idx;
        w_err  <= aw_err;
        w_mis  <= 1'b0;
        w_over <= 1'b0;
      end else if (w_hs) begin
        w_idx <= w_idx + IDX_ONE;
        if (w_left != 8'd0) w_left <= w_left - 8'd1;
        else                w_over <= 1'b1;
        if (s_wlast != (w_left == 8'd0)) w_mis <= 1'b1;
      end
    end
  end

  assign s_awready = rdy_en && (w_state == W_IDLE);
  assign s_wready  = (w_state == W_DATA);
  assign s_bvalid  = (w_state == W_RESP);
  assign s_bresp   = (s_bvalid && (w_err || w_mis)) ? 2'b10 : 2'b00;
  assign s_bid     = w_id;

endmodule
